stack_mem_arbiter: RTL and testbench
====================================

STACK_MEM_ARBITER -- requirements
Module: stack_mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W default 5, memory address width; DATA_W default 8, data width; STACK_BASE default 24, lowest stack address; DEPTH default 8, maximum stack entries (STACK_BASE+DEPTH <= 2^ADDR_W).
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 if_req  in  1  instruction-fetch read request; held stable until if_ack.
REQ-005 if_addr  in  ADDR_W  fetch address; held stable until if_ack.
REQ-006 if_ack  out  1  one-cycle fetch completion pulse.
REQ-007 if_rdata  out  DATA_W  registered fetch data; valid while if_ack is high and held until the next fetch capture.
REQ-008 st_req  in  1  stack request; held stable until st_ack.
REQ-009 st_op  in  2  stack operation: 00 push, 01 pop, 10 tos (read top, no SP change), 11 reserved.
REQ-010 st_wdata  in  DATA_W  push data.
REQ-011 st_ack  out  1  one-cycle stack completion pulse.
REQ-012 st_err  out  1  high with st_ack when the operation was rejected.
REQ-013 st_rdata  out  DATA_W  registered pop/tos data; held until the next stack capture.
REQ-014 mem_addr  out  ADDR_W  shared single-port memory address.
REQ-015 mem_we  out  1  memory write enable.
REQ-016 mem_wdata  out  DATA_W  memory write data.
REQ-017 mem_rdata  in  DATA_W  synchronous-read data, valid the cycle after mem_addr is presented.
REQ-018 sp  out  ADDR_W  stack entry count, 0..DEPTH.
REQ-019 empty  out  1  (sp == 0); full  out  1  (sp == DEPTH).

Function
REQ-020 The FSM SHALL have states IDLE, IF_ADDR, IF_DATA, ST_ADDR, ST_DATA, ST_WR, ACK.
REQ-021 In IDLE with only if_req high, next state SHALL be IF_ADDR; with only st_req high, it SHALL be the stack path of REQ-024..REQ-027.
REQ-022 With both requests high in IDLE, the grant SHALL go to the requester not granted last, and last_grant SHALL be updated on every grant.
REQ-023 Fetch path: IF_ADDR drives mem_addr=if_addr; IF_DATA captures mem_rdata into if_rdata; ACK pulses if_ack; total 3 cycles from the IDLE sample to the ack.
REQ-024 Push with full=0: ST_WR SHALL drive mem_addr=STACK_BASE+sp, mem_we=1, mem_wdata=st_wdata and increment sp; ACK follows; 2 cycles total.
REQ-025 Pop/tos with empty=0: ST_ADDR SHALL drive mem_addr=STACK_BASE+sp-1; ST_DATA captures st_rdata; ACK follows; 3 cycles total.
REQ-026 Pop SHALL decrement sp in ST_DATA, and tos SHALL leave sp unchanged.
REQ-027 Push when full, pop/tos when empty, or st_op=11 SHALL go IDLE->ACK with st_ack=1 and st_err=1, with no memory access, no sp change and no st_rdata change.
REQ-028 ACK SHALL return to IDLE; the acked requester deasserts its req on the edge ending ACK, so re-grant is possible no earlier than the next IDLE cycle.
REQ-029 Outside IF_ADDR, ST_ADDR and ST_WR, mem_addr SHALL be 0, mem_we SHALL be 0 and mem_wdata SHALL be 0; mem_we SHALL be high only in ST_WR.
REQ-030 A request arriving during a non-IDLE state SHALL wait; there is no preemption, and the waiting request wins the next IDLE by REQ-022.
REQ-031 sp arithmetic SHALL be ADDR_W-bit; sp never exceeds DEPTH or goes below 0, guaranteed by REQ-027.

Reset
REQ-032 rst=1 at a clock edge SHALL force state IDLE, sp=0, last_grant=stack (so fetch wins the first conflict), if_rdata=0, st_rdata=0, and all acks and st_err to 0.
REQ-033 Reset during any state, including ST_WR, SHALL abort the operation with no ack; mem_we SHALL be 0 in any cycle where rst=1.

Verification
REQ-034 Reset; push 0xA5, push 0x3C -> sp=2, mem[24]=0xA5, mem[25]=0x3C, each st_ack 2 cycles after request, st_err=0.
REQ-035 Then pop -> st_rdata=0x3C, sp=1, ack 3 cycles after request; tos -> st_rdata=0xA5, sp=1.
REQ-036 Pop with sp=0 -> st_ack=st_err=1 one cycle after request, sp=0, no mem_we; 9 pushes with DEPTH=8 -> 9th push errors, full=1, sp=8.
REQ-037 if_req and st_req raised in the same cycle after reset -> fetch acked first (3 cycles), then the stack op; repeat -> grant alternates.
REQ-038 Assert rst during ST_WR of a push -> no write, no ack, sp=0, state IDLE next cycle.

Source files
------------

// File: rtl/stack_mem_arbiter.sv
// Arbiter sharing one synchronous-read single-port memory between an
// instruction-fetch read port and a hardware stack (push / pop / tos).
// Round-robin grant between the two requesters, one transaction at a time.
module stack_mem_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 8,
  parameter int STACK_BASE = 24,
  parameter int DEPTH      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              st_req,
  input  logic [1:0]        st_op,
  input  logic [DATA_W-1:0] st_wdata,
  output logic              st_ack,
  output logic              st_err,
  output logic [DATA_W-1:0] st_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] sp,
  output logic              empty,
  output logic              full
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    IF_ADDR = 3'd1,
    IF_DATA = 3'd2,
    ST_ADDR = 3'd3,
    ST_DATA = 3'd4,
    ST_WR   = 3'd5,
    ACK     = 3'd6
  } state_t;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_TOS  = 2'b10;

  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(STACK_BASE);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  state_t state;
  state_t state_nxt;

  // last_grant: 1 = stack was granted last (also marks the owner of the
  // transaction in flight, since it is updated on every grant)
  logic last_grant;
  logic err_q;
  logic grant_if;
  logic grant_st;
  logic st_bad;
  logic [ADDR_W-1:0] push_addr;
  logic [ADDR_W-1:0] top_addr;

  assign empty     = (sp == '0);
  assign full      = (sp == DEPTH_A);
  assign push_addr = BASE_A + sp;
  assign top_addr  = BASE_A + sp - ONE_A;

  // Rejected stack ops: overflow, underflow or the reserved opcode
  assign st_bad = (st_op == 2'b11) ||
                  ((st_op == OP_PUSH) && full) ||
                  (((st_op == OP_POP) || (st_op == OP_TOS)) && empty);

  // Round-robin: on a conflict the requester not granted last wins
  assign grant_st = st_req && (!if_req || !last_grant);
  assign grant_if = if_req && !grant_st;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_if)                 state_nxt = IF_ADDR;
        else if (grant_st && st_bad)  state_nxt = ACK;
        else if (grant_st && (st_op == OP_PUSH)) state_nxt = ST_WR;
        else if (grant_st)            state_nxt = ST_ADDR;
        else                          state_nxt = IDLE;
      end
      IF_ADDR: state_nxt = IF_DATA;
      IF_DATA: state_nxt = ACK;
      ST_ADDR: state_nxt = ST_DATA;
      ST_DATA: state_nxt = ACK;
      ST_WR:   state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; memory bus is idle-zero outside access states
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if_ack    = 1'b0;
    st_ack    = 1'b0;
    st_err    = 1'b0;
    case (state)
      IF_ADDR: mem_addr = if_addr;
      ST_ADDR: mem_addr = top_addr;
      ST_WR: begin
        mem_addr  = push_addr;
        mem_we    = !rst;
        mem_wdata = st_wdata;
      end
      ACK: begin
        if_ack = !last_grant;
        st_ack = last_grant;
        st_err = last_grant && err_q;
      end
      default: ;
    endcase
  end

  // Grant tracking, stack pointer and registered read data
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      err_q      <= 1'b0;
      sp         <= '0;
      if_rdata   <= '0;
      st_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_if) begin
            last_grant <= 1'b0;
            err_q      <= 1'b0;
          end else if (grant_st) begin
            last_grant <= 1'b1;
            err_q      <= st_bad;
          end
        end
        IF_DATA: if_rdata <= mem_rdata;
        ST_DATA: begin
          st_rdata <= mem_rdata;
          if (st_op == OP_POP) sp <= sp - ONE_A;
        end
        ST_WR: sp <= sp + ONE_A;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_mem_arbiter.sv
// Self-checking bench for stack_mem_arbiter: table-driven stack ops,
// push-to-full loop, fetch/stack conflicts and reset during a write.
module tb_stack_mem_arbiter;

  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 8;
  localparam int STACK_BASE = 24;
  localparam int DEPTH      = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              st_req;
  logic [1:0]        st_op;
  logic [DATA_W-1:0] st_wdata;
  logic              st_ack;
  logic              st_err;
  logic [DATA_W-1:0] st_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] sp;
  logic              empty;
  logic              full;

  stack_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STACK_BASE(STACK_BASE), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .st_req(st_req), .st_op(st_op), .st_wdata(st_wdata),
    .st_ack(st_ack), .st_err(st_err), .st_rdata(st_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .sp(sp), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int we_count = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_we) we_count <= we_count + 1;

  // Synchronous-read memory model; contents mem[i] = i*7+3 at start
  logic [DATA_W-1:0] mem [0:31];
  bit loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'(i * 7 + 3);
      loaded <= 1'b1;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    logic [1:0] op;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       err;
    logic [4:0] sp;
    int         lat;
  } vec_t;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
    int         lat;
  } fv_t;

  vec_t st_q[$];
  fv_t  if_q[$];
  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic stack_txn(input string nm, input vec_t v);
    int c0;
    int w0;
    bit got;
    vec_t e;
    @(negedge clk);
    st_op = v.op;
    st_wdata = v.wdata;
    st_req = 1'b1;
    st_q.push_back(v);
    c0 = cyc;
    w0 = we_count;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (st_ack) begin
        got = 1'b1;
        st_req = 1'b0;
        e = st_q.pop_front();
        chk({nm, "_lat"},   32'(cyc - c0), 32'(e.lat));
        chk({nm, "_err"},   32'(st_err),   32'(e.err));
        chk({nm, "_rdata"}, 32'(st_rdata), 32'(e.rdata));
        chk({nm, "_sp"},    32'(sp),       32'(e.sp));
        chk({nm, "_full"},  32'(full),     32'(e.sp == 5'(DEPTH)));
        chk({nm, "_empty"}, 32'(empty),    32'(e.sp == 5'd0));
        chk({nm, "_we"},    32'(we_count - w0), 32'((e.op == 2'b00) && !e.err));
      end
    end
    if (!got) begin
      tests++;
      fails++;
      st_req = 1'b0;
      st_q.delete();
      $display("FAIL %s_timeout: no st_ack within 20 cycles", nm);
    end
  endtask

  task automatic fetch_txn(input string nm, input fv_t v);
    int c0;
    bit got;
    fv_t e;
    @(negedge clk);
    if_addr = v.addr;
    if_req = 1'b1;
    if_q.push_back(v);
    c0 = cyc;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (if_ack) begin
        got = 1'b1;
        if_req = 1'b0;
        e = if_q.pop_front();
        chk({nm, "_lat"},   32'(cyc - c0), 32'(e.lat));
        chk({nm, "_rdata"}, 32'(if_rdata), 32'(e.data));
        chk({nm, "_sterr"}, 32'(st_err),   32'd0);
      end
    end
    if (!got) begin
      tests++;
      fails++;
      if_req = 1'b0;
      if_q.delete();
      $display("FAIL %s_timeout: no if_ack within 20 cycles", nm);
    end
  endtask

  initial begin
    int w0;
    bit ack_seen;
    vec_t v;
    fv_t f;

    //           op     wdata  rdata  err  sp    lat
    vecs[0] = '{2'b00, 8'hA5, 8'h00, 1'b0, 5'd1, 2};
    vecs[1] = '{2'b00, 8'h3C, 8'h00, 1'b0, 5'd2, 2};
    vecs[2] = '{2'b01, 8'h00, 8'h3C, 1'b0, 5'd1, 3};
    vecs[3] = '{2'b10, 8'h00, 8'hA5, 1'b0, 5'd1, 3};
    vecs[4] = '{2'b01, 8'h00, 8'hA5, 1'b0, 5'd0, 3};
    vecs[5] = '{2'b01, 8'h00, 8'hA5, 1'b1, 5'd0, 1};
    vecs[6] = '{2'b10, 8'h00, 8'hA5, 1'b1, 5'd0, 1};
    vecs[7] = '{2'b11, 8'h77, 8'hA5, 1'b1, 5'd0, 1};

    rst = 1'b1;
    if_req = 1'b0;
    if_addr = '0;
    st_req = 1'b0;
    st_op = 2'b00;
    st_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sp",       32'(sp),       32'd0);
    chk("rst_empty",    32'(empty),    32'd1);
    chk("rst_full",     32'(full),     32'd0);
    chk("rst_if_ack",   32'(if_ack),   32'd0);
    chk("rst_st_ack",   32'(st_ack),   32'd0);
    chk("rst_st_err",   32'(st_err),   32'd0);
    chk("rst_if_rdata", 32'(if_rdata), 32'd0);
    chk("rst_st_rdata", 32'(st_rdata), 32'd0);
    chk("rst_mem_we",   32'(mem_we),   32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) stack_txn($sformatf("vec%0d", i), vecs[i]);
    @(negedge clk);
    chk("mem24", 32'(mem[24]), 32'h A5);
    chk("mem25", 32'(mem[25]), 32'h 3C);

    // Fill to DEPTH; the ninth push must be rejected
    for (int i = 0; i < 9; i++) begin
      v = '{2'b00, 8'(8'h10 + i), 8'hA5, (i == 8), (i < 8) ? 5'(i + 1) : 5'd8, (i == 8) ? 1 : 2};
      stack_txn($sformatf("fill%0d", i), v);
    end
    @(negedge clk);
    chk("mem31", 32'(mem[31]), 32'h17);

    // Conflict after a stack grant: fetch wins, stack waits
    v = '{2'b10, 8'h00, 8'h17, 1'b0, 5'd8, 7};
    f = '{5'd5, 8'h26, 3};
    fork
      stack_txn("cfl1_st", v);
      fetch_txn("cfl1_if", f);
    join

    f = '{5'd12, 8'h57, 3};
    fetch_txn("solo_if", f);

    // Conflict after a fetch grant: stack wins
    v = '{2'b01, 8'h00, 8'h17, 1'b0, 5'd7, 3};
    f = '{5'd23, 8'hA4, 7};
    fork
      stack_txn("cfl2_st", v);
      fetch_txn("cfl2_if", f);
    join

    // Reset while the push sits in ST_WR
    @(negedge clk);
    st_op = 2'b00;
    st_wdata = 8'h99;
    st_req = 1'b1;
    w0 = we_count;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstwr_mem_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    st_req = 1'b0;
    chk("rstwr_sp",       32'(sp),       32'd0);
    chk("rstwr_st_ack",   32'(st_ack),   32'd0);
    chk("rstwr_mem_addr", 32'(mem_addr), 32'd0);
    chk("rstwr_if_rdata", 32'(if_rdata), 32'd0);
    ack_seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (st_ack || if_ack) ack_seen = 1'b1;
    end
    chk("rstwr_no_ack", 32'(ack_seen), 32'd0);
    chk("rstwr_we",     32'(we_count - w0), 32'd0);

    f = '{5'd0, 8'h03, 3};
    fetch_txn("post_rst_if", f);
    v = '{2'b00, 8'h42, 8'h00, 1'b0, 5'd1, 2};
    stack_txn("post_rst_push", v);
    @(negedge clk);
    chk("mem24_post", 32'(mem[24]), 32'h42);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
